// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial program loader: SPI-like byte stream into CPU program memory
// Holds the CPU in reset while a frame is shifted in and written from address 0 upwards.
module prog_loader #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic              ld_sclk_i,
   input  logic              ld_csn_i,
   input  logic              ld_mosi_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              cpu_rst_n_o,
   output logic              ld_busy_o,
   output logic              ld_done_o,
   output logic              ld_err_o,
   output logic [ADDR_W:0]   ld_count_o
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, WRITE, FINISH} state_t;

   logic [SYNC_STAGES-1:0] sclk_sr, csn_sr, mosi_sr;
   logic [SYNC_STAGES:0]   primed;
   logic                   sclk_d, csn_d;
   logic                   sclk_s, csn_s, mosi_s;
   logic                   sclk_rise, csn_rise, csn_fall;

   state_t                 state, state_n;
   logic [CNT_W-1:0]       bit_cnt, bit_cnt_n, cnt_inc;
   logic [DATA_W-1:0]      shreg, shreg_n, shreg_shift;
   logic                   full, full_n, fin_pend, fin_pend_n;
   logic                   we_n, cpu_rst_n_n, busy_n, done_n, err_n;
   logic [ADDR_W-1:0]      addr_n;
   logic [DATA_W-1:0]      wdata_n;
   logic [ADDR_W:0]        count_n;

   assign sclk_s      = sclk_sr[SYNC_STAGES-1];
   assign csn_s       = csn_sr[SYNC_STAGES-1];
   assign mosi_s      = mosi_sr[SYNC_STAGES-1];
   assign sclk_rise   = sclk_s & ~sclk_d;
   assign csn_rise    = csn_s & ~csn_d;
   // csn_d only reflects a real pad sample once the chain has flushed, so a frame
   // already in progress at reset release is not mistaken for a new start.
   assign csn_fall    = primed[SYNC_STAGES] & csn_d & ~csn_s;
   assign cnt_inc     = bit_cnt + CNT_W'(1);
   assign shreg_shift = {shreg[DATA_W-2:0], mosi_s};

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         sclk_sr <= '0;
         csn_sr  <= '1;
         mosi_sr <= '0;
         primed  <= '0;
         sclk_d  <= 1'b0;
         csn_d   <= 1'b1;
      end else begin
         sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], ld_sclk_i};
         csn_sr  <= {csn_sr[SYNC_STAGES-2:0], ld_csn_i};
         mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], ld_mosi_i};
         primed  <= {primed[SYNC_STAGES-1:0], 1'b1};
         sclk_d  <= sclk_s;
         csn_d   <= csn_s;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shreg       <= '0;
         full        <= 1'b0;
         fin_pend    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         cpu_rst_n_o <= 1'b0;
         ld_busy_o   <= 1'b0;
         ld_done_o   <= 1'b0;
         ld_err_o    <= 1'b0;
         ld_count_o  <= '0;
      end else begin
         state       <= state_n;
         bit_cnt     <= bit_cnt_n;
         shreg       <= shreg_n;
         full        <= full_n;
         fin_pend    <= fin_pend_n;
         mem_we_o    <= we_n;
         mem_addr_o  <= addr_n;
         mem_wdata_o <= wdata_n;
         cpu_rst_n_o <= cpu_rst_n_n;
         ld_busy_o   <= busy_n;
         ld_done_o   <= done_n;
         ld_err_o    <= err_n;
         ld_count_o  <= count_n;
      end
   end

   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shreg_n     = shreg;
      full_n      = full;
      fin_pend_n  = fin_pend;
      we_n        = 1'b0;
      addr_n      = mem_addr_o;
      wdata_n     = mem_wdata_o;
      cpu_rst_n_n = cpu_rst_n_o;
      busy_n      = ld_busy_o;
      done_n      = ld_done_o;
      err_n       = ld_err_o;
      count_n     = ld_count_o;
      case (state)
         IDLE: begin
            cpu_rst_n_n = 1'b1;
            if (csn_fall) begin
               state_n     = SHIFT;
               bit_cnt_n   = '0;
               addr_n      = '0;
               count_n     = '0;
               cpu_rst_n_n = 1'b0;
               busy_n      = 1'b1;
               done_n      = 1'b0;
               err_n       = 1'b0;
               full_n      = 1'b0;
               fin_pend_n  = 1'b0;
            end
         end
         SHIFT: begin
            if (sclk_rise) begin
               shreg_n = shreg_shift;
               if (cnt_inc == CNT_W'(DATA_W)) begin
                  bit_cnt_n = '0;
                  if (full) begin
                     err_n = 1'b1;
                  end else begin
                     wdata_n = shreg_shift;
                     we_n    = 1'b1;
                     state_n = WRITE;
                  end
               end else begin
                  bit_cnt_n = cnt_inc;
               end
            end
            // A word completing together with csn rising is written before finishing.
            if (csn_rise) begin
               if (state_n == WRITE) fin_pend_n = 1'b1;
               else                  state_n    = FINISH;
            end
         end
         WRITE: begin
            if (sclk_rise) begin
               shreg_n   = shreg_shift;
               bit_cnt_n = cnt_inc;
            end
            count_n = ld_count_o + (ADDR_W+1)'(1);
            if (mem_addr_o == '1) full_n = 1'b1;
            else                  addr_n = mem_addr_o + ADDR_W'(1);
            state_n    = (fin_pend || csn_rise) ? FINISH : SHIFT;
            fin_pend_n = 1'b0;
         end
         FINISH: begin
            if (bit_cnt != '0) err_n = 1'b1;
            bit_cnt_n   = '0;
            busy_n      = 1'b0;
            done_n      = 1'b1;
            cpu_rst_n_n = 1'b1;
            state_n     = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
// Two instances share the pads: full-size (A) and a 4-byte memory (B) for overflow.
module tb_prog_loader;
   logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, csn = 1'b1, mosi = 1'b0;

   logic       we_a, cpu_a, busy_a, done_a, err_a;
   logic [7:0] addr_a, wdata_a;
   logic [8:0] count_a;
   logic       we_b, cpu_b, busy_b, done_b, err_b;
   logic [1:0] addr_b;
   logic [7:0] wdata_b;
   logic [2:0] count_b;

   int n_cmp = 0, n_fail = 0;
   logic [15:0] wr_a[$];
   logic [9:0]  wr_b[$];
   int busy_cyc = 0, bad_cpu = 0, cpu_low = 0, we_long = 0;
   logic prev_we_a = 1'b0;
   logic [7:0] frame_bytes[16];

   prog_loader #(.ADDR_W(8), .DATA_W(8), .SYNC_STAGES(2)) dut (
      .wb_clk_i(clk), .wb_rst_n(rst_n), .ld_sclk_i(sclk), .ld_csn_i(csn), .ld_mosi_i(mosi),
      .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_wdata_o(wdata_a), .cpu_rst_n_o(cpu_a),
      .ld_busy_o(busy_a), .ld_done_o(done_a), .ld_err_o(err_a), .ld_count_o(count_a));

   prog_loader #(.ADDR_W(2), .DATA_W(8), .SYNC_STAGES(2)) dut_small (
      .wb_clk_i(clk), .wb_rst_n(rst_n), .ld_sclk_i(sclk), .ld_csn_i(csn), .ld_mosi_i(mosi),
      .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_wdata_o(wdata_b), .cpu_rst_n_o(cpu_b),
      .ld_busy_o(busy_b), .ld_done_o(done_b), .ld_err_o(err_b), .ld_count_o(count_b));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we_a) wr_a.push_back({addr_a, wdata_a});
      if (we_b) wr_b.push_back({addr_b, wdata_b});
      if (busy_a) busy_cyc++;
      if (busy_a && cpu_a) bad_cpu++;
      if (!cpu_a) cpu_low++;
      if (we_a && prev_we_a) we_long++;
      prev_we_a = we_a;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input int h, input logic raise_csn);
      mosi = b;
      wait_clks(h);
      sclk = 1'b1;
      if (raise_csn) csn = 1'b1;
      wait_clks(h);
      sclk = 1'b0;
   endtask

   task automatic send_frame(input int n, input int extra, input int h, input logic coincide);
      csn = 1'b0;
      wait_clks(h);
      for (int i = 0; i < n; i++)
         for (int j = 7; j >= 0; j--)
            send_bit(frame_bytes[i][j], h, coincide && (i == n-1) && (j == 0) && (extra == 0));
      for (int e = 0; e < extra; e++)
         send_bit(1'($urandom_range(0, 1)), h, 1'b0);
      wait_clks(h);
      csn = 1'b1;
      wait_clks(12);
   endtask

   task automatic test_reset;
      wait_clks(3);
      n_cmp++;
      if ({we_a, addr_a, wdata_a, cpu_a, busy_a, done_a, err_a, count_a} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 0",
                  {we_a, addr_a, wdata_a, cpu_a, busy_a, done_a, err_a, count_a});
      end
      rst_n = 1'b1;
      wait_clks(1);
      n_cmp++;
      if (cpu_a !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_release: got %b want 1", cpu_a); end
   endtask

   task automatic test_basic;
      int b0, c0, w0;
      logic [15:0] exp;
      frame_bytes[0] = 8'hA5; frame_bytes[1] = 8'h3C; frame_bytes[2] = 8'hFF;
      wr_a.delete();
      b0 = busy_cyc; c0 = bad_cpu; w0 = we_long;
      send_frame(3, 0, 4, 1'b0);
      n_cmp++;
      if (wr_a.size() !== 3) begin n_fail++; $display("FAIL basic_nwrites: got %0d want 3", wr_a.size()); end
      for (int i = 0; i < 3; i++) begin
         exp = {8'(i), frame_bytes[i]};
         n_cmp++;
         if (i >= wr_a.size() || wr_a[i] !== exp) begin
            n_fail++;
            $display("FAIL basic_write%0d: got %h want %h", i, (i < wr_a.size()) ? wr_a[i] : 16'hxxxx, exp);
         end
      end
      n_cmp++;
      if ({count_a, done_a, err_a, busy_a, cpu_a} !== {9'd3, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL basic_status: got cnt=%0d done=%b err=%b busy=%b cpu=%b want 3 1 0 0 1",
                  count_a, done_a, err_a, busy_a, cpu_a);
      end
      n_cmp++;
      if (busy_cyc == b0 || bad_cpu != c0) begin
         n_fail++;
         $display("FAIL basic_cpu_held: busy cycles %0d, cpu released while busy %0d want >0 and 0",
                  busy_cyc - b0, bad_cpu - c0);
      end
      n_cmp++;
      if (we_long != w0) begin n_fail++; $display("FAIL basic_we_width: got %0d long pulses want 0", we_long - w0); end
   endtask

   task automatic test_partial;
      frame_bytes[0] = 8'h81;
      wr_a.delete();
      send_frame(1, 5, 4, 1'b0);
      n_cmp++;
      if (wr_a.size() !== 1 || wr_a[0] !== 16'h0081) begin
         n_fail++;
         $display("FAIL partial_write: got n=%0d first=%h want n=1 0081", wr_a.size(), (wr_a.size() > 0) ? wr_a[0] : 16'hxxxx);
      end
      n_cmp++;
      if ({err_a, done_a, count_a} !== {1'b1, 1'b1, 9'd1}) begin
         n_fail++;
         $display("FAIL partial_status: got err=%b done=%b cnt=%0d want 1 1 1", err_a, done_a, count_a);
      end
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 5; i++) frame_bytes[i] = 8'(i + 1);
      wr_b.delete();
      wr_a.delete();
      send_frame(5, 0, 3, 1'b0);
      n_cmp++;
      if (wr_b.size() !== 4) begin n_fail++; $display("FAIL ovf_nwrites: got %0d want 4", wr_b.size()); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= wr_b.size() || wr_b[i] !== {2'(i), 8'(i + 1)}) begin
            n_fail++;
            $display("FAIL ovf_write%0d: got %h want %h", i, (i < wr_b.size()) ? wr_b[i] : 10'hxxx, {2'(i), 8'(i + 1)});
         end
      end
      n_cmp++;
      if ({err_b, addr_b, count_b, done_b} !== {1'b1, 2'd3, 3'd4, 1'b1}) begin
         n_fail++;
         $display("FAIL ovf_status: got err=%b addr=%0d cnt=%0d done=%b want 1 3 4 1", err_b, addr_b, count_b, done_b);
      end
      n_cmp++;
      if (wr_a.size() !== 5 || err_a !== 1'b0 || count_a !== 9'd5) begin
         n_fail++;
         $display("FAIL ovf_large_mem: got n=%0d err=%b cnt=%0d want 5 0 5", wr_a.size(), err_a, count_a);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [11:0] bits;
      bits = 12'hC3A;
      wr_a.delete();
      csn = 1'b0;
      wait_clks(4);
      for (int j = 11; j >= 0; j--) send_bit(bits[j], 4, 1'b0);
      n_cmp++;
      if (wr_a.size() !== 1 || wr_a[0] !== 16'h00C3) begin
         n_fail++;
         $display("FAIL rstmid_first_byte: got n=%0d want 1 write 00c3", wr_a.size());
      end
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({we_a, addr_a, wdata_a, cpu_a, busy_a, done_a, err_a, count_a} !== 30'd0) begin
         n_fail++;
         $display("FAIL rstmid_async: got %h want 0", {we_a, addr_a, wdata_a, cpu_a, busy_a, done_a, err_a, count_a});
      end
      wr_a.delete();
      for (int j = 0; j < 8; j++) send_bit(1'($urandom_range(0, 1)), 3, 1'b0);
      n_cmp++;
      if (wr_a.size() !== 0) begin n_fail++; $display("FAIL rstmid_in_reset: got %0d writes want 0", wr_a.size()); end
      rst_n = 1'b1;
      for (int j = 0; j < 16; j++) send_bit(1'($urandom_range(0, 1)), 3, 1'b0);
      n_cmp++;
      if (wr_a.size() !== 0 || busy_a !== 1'b0 || cpu_a !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_stale_frame: got writes=%0d busy=%b cpu=%b want 0 0 1", wr_a.size(), busy_a, cpu_a);
      end
      csn = 1'b1;
      wait_clks(10);
      frame_bytes[0] = 8'h5A;
      send_frame(1, 0, 4, 1'b0);
      n_cmp++;
      if (wr_a.size() !== 1 || wr_a[0] !== 16'h005A || done_a !== 1'b1 || err_a !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_new_frame: got n=%0d done=%b err=%b want 1 write 005a 1 0", wr_a.size(), done_a, err_a);
      end
   endtask

   task automatic test_idle_noise;
      int b0, l0;
      wr_a.delete();
      b0 = busy_cyc; l0 = cpu_low;
      csn = 1'b1;
      for (int j = 0; j < 20; j++) send_bit(1'($urandom_range(0, 1)), 3, 1'b0);
      wait_clks(5);
      n_cmp++;
      if (wr_a.size() !== 0 || busy_cyc != b0 || cpu_low != l0) begin
         n_fail++;
         $display("FAIL idle_noise: got writes=%0d busy_cyc=%0d cpu_low_cyc=%0d want 0 0 0",
                  wr_a.size(), busy_cyc - b0, cpu_low - l0);
      end
   endtask

   task automatic test_coincide;
      frame_bytes[0] = 8'h7E;
      wr_a.delete();
      send_frame(1, 0, 4, 1'b1);
      n_cmp++;
      if (wr_a.size() !== 1 || wr_a[0] !== 16'h007E) begin
         n_fail++;
         $display("FAIL coincide_write: got n=%0d want 1 write 007e", wr_a.size());
      end
      n_cmp++;
      if ({done_a, err_a, count_a} !== {1'b1, 1'b0, 9'd1}) begin
         n_fail++;
         $display("FAIL coincide_status: got done=%b err=%b cnt=%0d want 1 0 1", done_a, err_a, count_a);
      end
   endtask

   task automatic test_random;
      int n, extra, h, nb, exp_addr_b;
      logic exp_err_b;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 6);
         extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
         h = $urandom_range(3, 6);
         for (int i = 0; i < n; i++) frame_bytes[i] = 8'($urandom);
         wr_a.delete();
         wr_b.delete();
         send_frame(n, extra, h, 1'b0);
         nb = (n < 4) ? n : 4;
         exp_err_b = (extra != 0) || (n > 4);
         exp_addr_b = (n < 3) ? n : 3;
         n_cmp++;
         if (wr_a.size() !== n || wr_b.size() !== nb) begin
            n_fail++;
            $display("FAIL rand%0d_nwrites: got A=%0d B=%0d want %0d %0d", it, wr_a.size(), wr_b.size(), n, nb);
         end
         for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (i >= wr_a.size() || wr_a[i] !== {8'(i), frame_bytes[i]}) begin
               n_fail++;
               $display("FAIL rand%0d_write%0d: got %h want %h", it, i, (i < wr_a.size()) ? wr_a[i] : 16'hxxxx, {8'(i), frame_bytes[i]});
            end
         end
         n_cmp++;
         if ({count_a, err_a, done_a, addr_a} !== {9'(n), extra != 0, 1'b1, 8'(n)}) begin
            n_fail++;
            $display("FAIL rand%0d_status_a: got cnt=%0d err=%b done=%b addr=%0d want %0d %b 1 %0d",
                     it, count_a, err_a, done_a, addr_a, n, extra != 0, n);
         end
         n_cmp++;
         if ({count_b, err_b, addr_b} !== {3'(nb), exp_err_b, 2'(exp_addr_b)}) begin
            n_fail++;
            $display("FAIL rand%0d_status_b: got cnt=%0d err=%b addr=%0d want %0d %b %0d",
                     it, count_b, err_b, addr_b, nb, exp_err_b, exp_addr_b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_overflow();
      test_reset_mid_frame();
      test_idle_noise();
      test_coincide();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
